// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory request/ready handshake between fetch and imem
interface fetch_stage_if;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ready;
    logic [31:0] im_rdata;

    modport master (output im_req, output im_addr, input im_ready, input im_rdata);
    modport slave  (input im_req, input im_addr, output im_ready, output im_rdata);
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS IF stage with PC, next-PC select, imem handshake, skid buffer and IF/ID register
module fetch_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_stall,
    input  logic [1:0]            i_pcsel,
    input  logic [31:0]           i_npc_b,
    input  logic [31:0]           i_rd1_d,
    fetch_stage_if.master         im,
    output logic [31:0]           o_instr_d,
    output logic [31:0]           o_pc4_d,
    output logic [31:0]           o_pc_d,
    output logic                  o_valid_d
);
    typedef enum logic {FETCH, HOLD} state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, r_instr, r_pc4, r_pc_d, r_buf, r_pend_tgt;
    logic        r_valid, r_pend_v;
    logic [31:0] w_pc4, w_target, w_next_pc, w_instr;
    logic        w_redir, w_accept, w_bubble, w_capture;

    assign im.im_req   = reset && (r_state == FETCH);
    assign im.im_addr  = r_pc;
    assign o_instr_d   = r_instr;
    assign o_pc4_d     = r_pc4;
    assign o_pc_d      = r_pc_d;
    assign o_valid_d   = r_valid;

    assign w_pc4     = r_pc + 32'd4;
    assign w_target  = (i_pcsel == 2'b01) ? i_npc_b :
                       (i_pcsel == 2'b10) ? {r_pc4[31:28], r_instr[25:0], 2'b00} : i_rd1_d;
    assign w_redir   = r_valid && (i_pcsel != 2'b00);
    // A pending target wins: the branch that produced it has already left decode
    assign w_next_pc = r_pend_v ? r_pend_tgt : w_redir ? w_target : w_pc4;
    assign w_accept  = !i_stall && ((r_state == HOLD) || im.im_ready);
    assign w_bubble  = (r_state == FETCH) && !im.im_ready && !i_stall;
    assign w_capture = (r_state == FETCH) && im.im_ready && i_stall;
    assign w_instr   = (r_state == HOLD) ? r_buf : im.im_rdata;

    // Next state: park a stalled response in HOLD, leave HOLD once it is accepted
    always_comb begin
        w_state_nxt = r_state;
        if (w_capture)
            w_state_nxt = HOLD;
        else if (w_accept)
            w_state_nxt = FETCH;
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= FETCH;
        else
            r_state <= w_state_nxt;
    end

    // PC, IF/ID register, skid buffer and pending redirect target
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc       <= PC_RESET;
            r_instr    <= '0;
            r_pc4      <= '0;
            r_pc_d     <= '0;
            r_valid    <= 1'b0;
            r_buf      <= '0;
            r_pend_v   <= 1'b0;
            r_pend_tgt <= '0;
        end else begin
            if (w_accept) begin
                r_instr  <= w_instr;
                r_pc4    <= w_pc4;
                r_pc_d   <= r_pc;
                r_valid  <= 1'b1;
                r_pc     <= w_next_pc;
                r_pend_v <= 1'b0;
            end else if (w_bubble) begin
                r_instr <= '0;
                r_valid <= 1'b0;
                if (w_redir) begin
                    r_pend_v   <= 1'b1;
                    r_pend_tgt <= w_target;
                end
            end
            if (w_capture)
                r_buf <= im.im_rdata;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed table-driven check of fetch_stage plus async-reset-in-HOLD sequence
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic [1:0]  pcsel = 2'b00;
    logic [31:0] npc_b = '0;
    logic [31:0] rd1_d = '0;
    logic [31:0] instr_d, pc4_d, pc_d;
    logic        valid_d;
    int          n_cmp = 0;
    int          n_err = 0;

    fetch_stage_if bus();

    fetch_stage dut (
        .clk(clk), .reset(reset), .i_stall(stall), .i_pcsel(pcsel),
        .i_npc_b(npc_b), .i_rd1_d(rd1_d), .im(bus),
        .o_instr_d(instr_d), .o_pc4_d(pc4_d), .o_pc_d(pc_d), .o_valid_d(valid_d)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        stall;
        logic        rdy;
        logic [1:0]  sel;
        logic [31:0] npc;
        logic [31:0] rd1;
        logic [31:0] rdata;
        logic        req;
        logic [31:0] addr;
        logic [31:0] pc_d;
        logic [31:0] pc4_d;
        logic [31:0] instr;
        logic        valid;
    } vec_t;

    vec_t tbl [23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        //          stall rdy sel npc           rd1           rdata          req addr          pc_d          pc4_d         instr         valid
        tbl[0]  = '{1'b0,1'b1,2'd0,32'h0,       32'h0,        32'hA000_3000, 1'b1,32'h3000,     32'h3000,     32'h3004,     32'hA000_3000,1'b1};
        tbl[1]  = '{1'b0,1'b1,2'd0,32'h0,       32'h0,        32'h1000_0007, 1'b1,32'h3004,     32'h3004,     32'h3008,     32'h1000_0007,1'b1};
        tbl[2]  = '{1'b0,1'b1,2'd1,32'h3020,    32'h0,        32'hA000_3008, 1'b1,32'h3008,     32'h3008,     32'h300C,     32'hA000_3008,1'b1};
        tbl[3]  = '{1'b0,1'b1,2'd0,32'h0,       32'h0,        32'hA000_3020, 1'b1,32'h3020,     32'h3020,     32'h3024,     32'hA000_3020,1'b1};
        tbl[4]  = '{1'b0,1'b1,2'd0,32'h0,       32'h0,        32'h1000_000F, 1'b1,32'h3024,     32'h3024,     32'h3028,     32'h1000_000F,1'b1};
        tbl[5]  = '{1'b0,1'b0,2'd1,32'h3040,    32'h0,        32'hDEAD_BEEF, 1'b1,32'h3028,     32'h3024,     32'h3028,     32'h0,        1'b0};
        tbl[6]  = '{1'b0,1'b0,2'd1,32'hDEAD_0000,32'h0,       32'hDEAD_BEEF, 1'b1,32'h3028,     32'h3024,     32'h3028,     32'h0,        1'b0};
        tbl[7]  = '{1'b0,1'b1,2'd0,32'h0,       32'h0,        32'hA000_3028, 1'b1,32'h3028,     32'h3028,     32'h302C,     32'hA000_3028,1'b1};
        tbl[8]  = '{1'b0,1'b1,2'd0,32'h0,       32'h0,        32'hA000_3040, 1'b1,32'h3040,     32'h3040,     32'h3044,     32'hA000_3040,1'b1};
        tbl[9]  = '{1'b1,1'b1,2'd0,32'h0,       32'h0,        32'hA000_3044, 1'b1,32'h3044,     32'h3040,     32'h3044,     32'hA000_3040,1'b1};
        tbl[10] = '{1'b1,1'b0,2'd0,32'h0,       32'h0,        32'hDEAD_BEEF, 1'b0,32'h3044,     32'h3040,     32'h3044,     32'hA000_3040,1'b1};
        tbl[11] = '{1'b1,1'b0,2'd1,32'h5000,    32'h0,        32'hDEAD_BEEF, 1'b0,32'h3044,     32'h3040,     32'h3044,     32'hA000_3040,1'b1};
        tbl[12] = '{1'b0,1'b0,2'd0,32'h0,       32'h0,        32'hDEAD_BEEF, 1'b0,32'h3044,     32'h3044,     32'h3048,     32'hA000_3044,1'b1};
        tbl[13] = '{1'b0,1'b1,2'd0,32'h0,       32'h0,        32'h0C00_0040, 1'b1,32'h3048,     32'h3048,     32'h304C,     32'h0C00_0040,1'b1};
        tbl[14] = '{1'b0,1'b1,2'd2,32'h0,       32'h0,        32'hA000_304C, 1'b1,32'h304C,     32'h304C,     32'h3050,     32'hA000_304C,1'b1};
        tbl[15] = '{1'b0,1'b1,2'd0,32'h0,       32'h0,        32'h03E0_0008, 1'b1,32'h0100,     32'h0100,     32'h0104,     32'h03E0_0008,1'b1};
        tbl[16] = '{1'b0,1'b1,2'd3,32'h0,       32'h3100,     32'hA000_0104, 1'b1,32'h0104,     32'h0104,     32'h0108,     32'hA000_0104,1'b1};
        tbl[17] = '{1'b0,1'b1,2'd0,32'h0,       32'h0,        32'hA000_3100, 1'b1,32'h3100,     32'h3100,     32'h3104,     32'hA000_3100,1'b1};
        tbl[18] = '{1'b1,1'b0,2'd1,32'h5000,    32'h0,        32'hDEAD_BEEF, 1'b1,32'h3104,     32'h3100,     32'h3104,     32'hA000_3100,1'b1};
        tbl[19] = '{1'b0,1'b1,2'd0,32'h0,       32'h0,        32'hA000_3104, 1'b1,32'h3104,     32'h3104,     32'h3108,     32'hA000_3104,1'b1};
        tbl[20] = '{1'b0,1'b1,2'd3,32'h0,       32'hFFFF_FFFC,32'hA000_3108, 1'b1,32'h3108,     32'h3108,     32'h310C,     32'hA000_3108,1'b1};
        tbl[21] = '{1'b0,1'b1,2'd0,32'h0,       32'h0,        32'hA000_FFFC, 1'b1,32'hFFFF_FFFC,32'hFFFF_FFFC,32'h0000_0000,32'hA000_FFFC,1'b1};
        tbl[22] = '{1'b0,1'b1,2'd0,32'h0,       32'h0,        32'hA000_0000, 1'b1,32'h0000_0000,32'h0000_0000,32'h0000_0004,32'hA000_0000,1'b1};

        bus.im_ready = 1'b0;
        bus.im_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_req",   {31'b0, bus.im_req}, 32'h0);
        chk("rst_addr",  bus.im_addr, 32'h3000);
        chk("rst_valid", {31'b0, valid_d}, 32'h0);
        chk("rst_pc_d",  pc_d, 32'h0);
        chk("rst_pc4_d", pc4_d, 32'h0);
        chk("rst_instr", instr_d, 32'h0);
        reset = 1'b1;

        for (int i = 0; i < 23; i++) begin
            if (i > 0) @(negedge clk);
            stall = tbl[i].stall;
            bus.im_ready = tbl[i].rdy;
            pcsel = tbl[i].sel;
            npc_b = tbl[i].npc;
            rd1_d = tbl[i].rd1;
            bus.im_rdata = tbl[i].rdata;
            #1;
            chk($sformatf("v%0d_req", i),  {31'b0, bus.im_req}, {31'b0, tbl[i].req});
            chk($sformatf("v%0d_addr", i), bus.im_addr, tbl[i].addr);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_pc_d", i),  pc_d, tbl[i].pc_d);
            chk($sformatf("v%0d_pc4_d", i), pc4_d, tbl[i].pc4_d);
            chk($sformatf("v%0d_instr", i), instr_d, tbl[i].instr);
            chk($sformatf("v%0d_valid", i), {31'b0, valid_d}, {31'b0, tbl[i].valid});
        end

        @(negedge clk);
        stall = 1'b1;
        pcsel = 2'b00;
        bus.im_ready = 1'b1;
        bus.im_rdata = 32'hA000_0004;
        @(posedge clk);
        #1;
        chk("hold_req", {31'b0, bus.im_req}, 32'h0);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_req",   {31'b0, bus.im_req}, 32'h0);
        chk("arst_addr",  bus.im_addr, 32'h3000);
        chk("arst_valid", {31'b0, valid_d}, 32'h0);
        chk("arst_pc_d",  pc_d, 32'h0);
        chk("arst_pc4_d", pc4_d, 32'h0);
        chk("arst_instr", instr_d, 32'h0);

        @(negedge clk);
        reset = 1'b1;
        stall = 1'b0;
        bus.im_rdata = 32'hA000_3000;
        #1;
        chk("rel_req",  {31'b0, bus.im_req}, 32'h1);
        chk("rel_addr", bus.im_addr, 32'h3000);
        @(posedge clk);
        #1;
        chk("rel_pc_d",  pc_d, 32'h3000);
        chk("rel_instr", instr_d, 32'hA000_3000);
        chk("rel_valid", {31'b0, valid_d}, 32'h1);
        chk("rel_addr2", bus.im_addr, 32'h3004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage MIPS pipeline: owns the PC register, selects the next PC, drives a request/ready handshake to instruction memory, and holds the IF/ID pipeline register feeding decode. Its outputs `instr_D` and `PC4_D` feed the immediate extension unit, which returns the branch target `NPC_B`. Supports hazard-unit stalls, multi-cycle memory responses and MIPS branch delay slots, with no flush.

## Interface
- `PC_RESET`, 32'h0000_3000: PC value loaded on reset.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hazard unit: hold PC and IF/ID this cycle.
- `PCSel`  in  2  decode-stage next-PC select: 00 PC+4, 01 branch (`NPC_B`), 10 j/jal, 11 jr.
- `NPC_B`  in  32  branch target from extension unit.
- `RD1_D`  in  32  forwarded rs value, jr target.
- `im_req`  out  1  fetch request.
- `im_addr`  out  32  fetch address (= PC).
- `im_ready`  in  1  memory has `im_rdata` valid this cycle.
- `im_rdata`  in  32  fetched instruction.
- `instr_D`  out  32  IF/ID instruction.
- `PC4_D`  out  32  IF/ID PC+4.
- `PC_D`  out  32  IF/ID PC.
- `valid_D`  out  1  IF/ID holds a real instruction; 0 means bubble.

## Operation
- State: PC, IF/ID regs, FSM {FETCH, HOLD}, skid buffer `buf` (32), `pend_v` + `pend_tgt` (32).
- Target: 01 → `NPC_B`; 10 → {`PC4_D`[31:28], `instr_D`[25:0], 2'b00}; 11 → `RD1_D`. `redir` = `valid_D` && `PCSel` != 00.
- Next PC on accept: `pend_v` ? `pend_tgt` : `redir` ? target : PC+4. Adds are 32-bit, wrap modulo 2^32.
- FETCH: `im_req`=1, `im_addr`=PC.
  - `im_ready` && !`stall`: accept. IF/ID ← {`im_rdata`, PC+4, PC}, `valid_D`←1, PC ← next PC, `pend_v`←0.
  - `im_ready` && `stall`: `buf`←`im_rdata`, go HOLD. PC and IF/ID unchanged.
  - !`im_ready` && !`stall`: bubble. `instr_D`←0, `valid_D`←0, PC unchanged. If `redir`, set `pend_v`←1 and `pend_tgt`←target, because the branch leaves decode before its delay slot is fetched.
  - !`im_ready` && `stall`: everything holds.
- HOLD: `im_req`=0. When !`stall`, accept from `buf` using the same rules, then return to FETCH. When `stall`, hold.
- `redir` is ignored while `stall`=1. `pend_v`=1 and `redir` cannot both hold, since a bubble is in decode.
- Reset (asynchronous, any state, including mid-HOLD): PC=`PC_RESET`, FSM=FETCH, `instr_D`=0, `PC4_D`=0, `PC_D`=0, `valid_D`=0, `buf`=0, `pend_v`=0, `pend_tgt`=0. `im_req`=0 while `reset` is low.

## Timing
- `im_req`/`im_addr` combinational from state. Held stable while `im_req`=1 until `im_ready`.
- `im_rdata` is sampled only in a cycle with `im_ready`=1. Zero-wait memory (`im_ready` same cycle) gives one instruction per cycle.
- Fetch to decode latency: 1 cycle after accept.
- Delay slot: the instruction after a branch/jump always enters decode. The redirected address is fetched immediately after, with or without memory wait states.
- First request in the first cycle after `reset` rises, `im_addr`=`PC_RESET`.

## Test plan
- Reset, zero-wait memory, no redirects: after release, `im_addr` steps 0x3000, 0x3004, 0x3008 on consecutive cycles. Third edge gives `PC_D`=0x3008, `PC4_D`=0x300C, `valid_D`=1.
- beq at 0x3004 in decode, `PCSel`=01, `NPC_B`=0x3020, zero-wait: the delay slot at 0x3008 enters decode, then `im_addr`=0x3020.
- Same branch, `im_ready`=0 for 2 cycles on 0x3008: decode shows bubbles (`valid_D`=0, `instr_D`=0) and `pend_tgt`=0x3020. After ready, 0x3008 enters decode and the next `im_addr`=0x3020.
- `stall`=1 in the cycle `im_ready`=1 at 0x3010, held 3 cycles: `im_req`=0 and IF/ID unchanged. When `stall` falls, the buffered instruction enters decode with `PC_D`=0x3010, then `im_addr`=0x3014.
- jal 0x0C00_0040 with `PC4_D`=0x3008 → next fetch 0x0000_0100. jr with `RD1_D`=0x3100 → next fetch after delay slot 0x3100.
- Assert `reset` low during HOLD: all outputs go to reset values immediately, without a clock edge. After release, fetch restarts at 0x3000.
